// File: rtl/simplerxmcdma_dlw_pkg.sv
// Shared types and default sizing for the RX MCDMA deadlock watchdog.
package simplerxmcdma_dlw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DEADLOCK = 2'd2
  } dlw_state_t;

  localparam int DEF_THRESHOLD = 1024;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_EVT_W     = 8;
  localparam int DEF_AXIS_N    = 3;

endpackage

// File: rtl/simplerxmcdma_deadlock_watchdog.sv
// Turns the monitor's registered stall flag into a sticky deadlock decision once
// the stall has persisted THRESHOLD consecutive cycles; snapshots the stalled channels.
module simplerxmcdma_deadlock_watchdog
  import simplerxmcdma_dlw_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EVT_W     = DEF_EVT_W,
  parameter int AXIS_N    = DEF_AXIS_N
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [AXIS_N-1:0] axis_block_sigs,
  input  logic              clear,
  output logic              deadlock,
  output logic              deadlock_pulse,
  output logic [AXIS_N-1:0] blocked_mask,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [EVT_W-1:0]  event_count
);

  localparam logic [CNT_W-1:0] THR_VAL = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  dlw_state_t        r_state;
  dlw_state_t        w_stateNxt;
  logic [CNT_W-1:0]  r_run;
  logic [CNT_W-1:0]  w_runNxt;
  logic [CNT_W-1:0]  w_runInc;
  logic [AXIS_N-1:0] r_acc;
  logic [AXIS_N-1:0] w_accNxt;
  logic [AXIS_N-1:0] r_mask;
  logic [AXIS_N-1:0] w_maskNxt;
  logic [EVT_W-1:0]  r_evt;
  logic [EVT_W-1:0]  w_evtNxt;
  logic              r_deadlock;
  logic              r_pulse;
  logic              w_pulseNxt;

  assign w_runInc = r_run + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNxt;
  end

  // clear is checked ahead of the threshold hit so an acknowledge always aborts the run
  always_comb begin
    w_stateNxt = r_state;
    w_runNxt   = r_run;
    w_accNxt   = r_acc;
    w_maskNxt  = r_mask;
    w_evtNxt   = r_evt;
    w_pulseNxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_runNxt = '0;
        w_accNxt = '0;
        if (block) begin
          w_stateNxt = COUNTING;
          w_runNxt   = CNT_W'(1);
          w_accNxt   = axis_block_sigs;
        end
      end
      COUNTING: begin
        if (clear || !block) begin
          w_stateNxt = IDLE;
          w_runNxt   = '0;
          w_accNxt   = '0;
        end else if (w_runInc == THR_VAL) begin
          w_stateNxt = DEADLOCK;
          w_runNxt   = THR_VAL;
          w_maskNxt  = r_acc | axis_block_sigs;
          w_accNxt   = '0;
          w_pulseNxt = 1'b1;
          if (r_evt != EVT_MAX) w_evtNxt = r_evt + EVT_W'(1);
        end else begin
          w_runNxt = w_runInc;
          w_accNxt = r_acc | axis_block_sigs;
        end
      end
      DEADLOCK: begin
        if (clear) begin
          w_stateNxt = IDLE;
          w_runNxt   = '0;
          w_maskNxt  = '0;
          w_accNxt   = '0;
        end else if (block && (r_run != RUN_MAX)) begin
          w_runNxt = w_runInc;
        end
      end
      default: begin
        w_stateNxt = IDLE;
        w_runNxt   = '0;
        w_accNxt   = '0;
        w_maskNxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run      <= '0;
      r_acc      <= '0;
      r_mask     <= '0;
      r_evt      <= '0;
      r_deadlock <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_run      <= w_runNxt;
      r_acc      <= w_accNxt;
      r_mask     <= w_maskNxt;
      r_evt      <= w_evtNxt;
      r_deadlock <= (w_stateNxt == DEADLOCK);
      r_pulse    <= w_pulseNxt;
    end
  end

  assign deadlock       = r_deadlock;
  assign deadlock_pulse = r_pulse;
  assign blocked_mask   = r_mask;
  assign run_cycles     = r_run;
  assign event_count    = r_evt;

endmodule

// File: tb/tb_simplerxmcdma_deadlock_watchdog.sv
// Directed bench for the deadlock watchdog: a vector table for reset/detection,
// then hand-written sequences for clear, collision, glitch, saturation and reset.
module tb_simplerxmcdma_deadlock_watchdog;

  localparam int THR = 8;
  localparam int CW  = 8;
  localparam int EW  = 2;
  localparam int AN  = 3;

  logic          clock;
  logic          reset;
  logic          block;
  logic [AN-1:0] axisBlockSigs;
  logic          clear;
  logic          deadlock;
  logic          deadlockPulse;
  logic [AN-1:0] blockedMask;
  logic [CW-1:0] runCycles;
  logic [EW-1:0] eventCount;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          rst;
    logic          blk;
    logic [AN-1:0] axis;
    logic          clr;
    logic          expDl;
    logic          expPulse;
    logic [AN-1:0] expMask;
    logic [CW-1:0] expRun;
    logic [EW-1:0] expEvt;
  } vec_t;

  vec_t vecs[$];

  simplerxmcdma_deadlock_watchdog #(
    .THRESHOLD(THR),
    .CNT_W    (CW),
    .EVT_W    (EW),
    .AXIS_N   (AN)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .block          (block),
    .axis_block_sigs(axisBlockSigs),
    .clear          (clear),
    .deadlock       (deadlock),
    .deadlock_pulse (deadlockPulse),
    .blocked_mask   (blockedMask),
    .run_cycles     (runCycles),
    .event_count    (eventCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void addVec(input logic rst, input logic blk, input logic [AN-1:0] axis,
                                 input logic clr, input logic dl, input logic pulse,
                                 input logic [AN-1:0] mask, input logic [CW-1:0] run,
                                 input logic [EW-1:0] evt);
    vec_t v;
    v.rst = rst; v.blk = blk; v.axis = axis; v.clr = clr;
    v.expDl = dl; v.expPulse = pulse; v.expMask = mask; v.expRun = run; v.expEvt = evt;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic rst, input logic blk, input logic [AN-1:0] axis,
                               input logic clr);
    reset         = rst;
    block         = blk;
    axisBlockSigs = axis;
    clear         = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expDl, input logic expPulse,
                             input logic [AN-1:0] expMask, input logic [CW-1:0] expRun,
                             input logic [EW-1:0] expEvt);
    checks++;
    if (deadlock !== expDl) begin
      failures++;
      $display("[TB] FAIL %s deadlock actual=%0b expected=%0b", tag, deadlock, expDl);
    end
    checks++;
    if (deadlockPulse !== expPulse) begin
      failures++;
      $display("[TB] FAIL %s deadlock_pulse actual=%0b expected=%0b", tag, deadlockPulse, expPulse);
    end
    checks++;
    if (blockedMask !== expMask) begin
      failures++;
      $display("[TB] FAIL %s blocked_mask actual=%b expected=%b", tag, blockedMask, expMask);
    end
    checks++;
    if (runCycles !== expRun) begin
      failures++;
      $display("[TB] FAIL %s run_cycles actual=%0d expected=%0d", tag, runCycles, expRun);
    end
    checks++;
    if (eventCount !== expEvt) begin
      failures++;
      $display("[TB] FAIL %s event_count actual=%0d expected=%0d", tag, eventCount, expEvt);
    end
  endtask

  initial begin
    reset         = 1'b1;
    block         = 1'b0;
    axisBlockSigs = '0;
    clear         = 1'b0;

    // Reset, a 7-cycle run that stays below threshold, then detection with mask 001|100
    addVec(1, 0, 3'b000, 0, 0, 0, 3'b000, 8'd0, 2'd0);
    addVec(1, 0, 3'b000, 0, 0, 0, 3'b000, 8'd0, 2'd0);
    for (int i = 1; i <= 7; i++) addVec(0, 1, 3'b000, 0, 0, 0, 3'b000, 8'(i), 2'd0);
    addVec(0, 0, 3'b000, 0, 0, 0, 3'b000, 8'd0, 2'd0);
    addVec(0, 1, 3'b001, 0, 0, 0, 3'b000, 8'd1, 2'd0);
    for (int i = 2; i <= 7; i++) addVec(0, 1, 3'b100, 0, 0, 0, 3'b000, 8'(i), 2'd0);
    addVec(0, 1, 3'b100, 0, 1, 1, 3'b101, 8'd8, 2'd1);
    addVec(0, 1, 3'b000, 0, 1, 0, 3'b101, 8'd9, 2'd1);
    addVec(0, 0, 3'b000, 0, 1, 0, 3'b101, 8'd9, 2'd1);
    addVec(0, 0, 3'b010, 0, 1, 0, 3'b101, 8'd9, 2'd1);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].blk, vecs[k].axis, vecs[k].clr);
      checkOutput($sformatf("vec%0d", k), vecs[k].expDl, vecs[k].expPulse,
                  vecs[k].expMask, vecs[k].expRun, vecs[k].expEvt);
    end

    // Clear with block still high, then re-arm into a second deadlock
    applyStimulus(0, 1, 3'b010, 1);
    checkOutput("clear", 0, 0, 3'b000, 8'd0, 2'd1);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, 3'b010, 0);
      checkOutput($sformatf("rearm%0d", i), 0, 0, 3'b000, 8'(i), 2'd1);
    end
    applyStimulus(0, 1, 3'b010, 0);
    checkOutput("rearm_hit", 1, 1, 3'b010, 8'd8, 2'd2);
    applyStimulus(0, 1, 3'b010, 0);
    checkOutput("rearm_after", 1, 0, 3'b010, 8'd9, 2'd2);
    applyStimulus(0, 0, 3'b000, 1);
    checkOutput("rearm_clear", 0, 0, 3'b000, 8'd0, 2'd2);

    // Clear on the same edge the threshold would be reached
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, 3'b110, 0);
      checkOutput($sformatf("coll_run%0d", i), 0, 0, 3'b000, 8'(i), 2'd2);
    end
    applyStimulus(0, 1, 3'b110, 1);
    checkOutput("collision", 0, 0, 3'b000, 8'd0, 2'd2);
    applyStimulus(0, 0, 3'b000, 0);
    checkOutput("collision_idle", 0, 0, 3'b000, 8'd0, 2'd2);

    // One low sample after 5 cycles restarts the window
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 3'b001, 0);
      checkOutput($sformatf("glitch_pre%0d", i), 0, 0, 3'b000, 8'(i), 2'd2);
    end
    applyStimulus(0, 0, 3'b000, 0);
    checkOutput("glitch_low", 0, 0, 3'b000, 8'd0, 2'd2);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, 3'b001, 0);
      checkOutput($sformatf("glitch_post%0d", i), 0, 0, 3'b000, 8'(i), 2'd2);
    end
    applyStimulus(0, 1, 3'b001, 0);
    checkOutput("glitch_hit", 1, 1, 3'b001, 8'd8, 2'd3);
    applyStimulus(0, 0, 3'b000, 1);
    checkOutput("glitch_clear", 0, 0, 3'b000, 8'd0, 2'd3);

    // Five deadlocks from a fresh reset: count saturates at 3, pulses continue
    applyStimulus(1, 0, 3'b000, 0);
    checkOutput("sat_reset", 0, 0, 3'b000, 8'd0, 2'd0);
    for (int k = 1; k <= 5; k++) begin
      int evtBefore;
      int evtAfter;
      evtBefore = (k - 1 > 3) ? 3 : k - 1;
      evtAfter  = (k > 3) ? 3 : k;
      for (int i = 1; i <= 7; i++) begin
        applyStimulus(0, 1, 3'b011, 0);
        checkOutput($sformatf("sat%0d_run%0d", k, i), 0, 0, 3'b000, 8'(i), 2'(evtBefore));
      end
      applyStimulus(0, 1, 3'b011, 0);
      checkOutput($sformatf("sat%0d_hit", k), 1, 1, 3'b011, 8'd8, 2'(evtAfter));
      if (k < 5) begin
        applyStimulus(0, 0, 3'b000, 1);
        checkOutput($sformatf("sat%0d_clear", k), 0, 0, 3'b000, 8'd0, 2'(evtAfter));
      end
    end

    // run_cycles saturates at 255 while the stall persists in DEADLOCK
    for (int i = 0; i < 250; i++) applyStimulus(0, 1, 3'b100, 0);
    checkOutput("run_sat", 1, 0, 3'b011, 8'd255, 2'd3);

    // Reset mid-deadlock, then reset mid-run
    applyStimulus(1, 1, 3'b011, 0);
    checkOutput("reset_dl", 0, 0, 3'b000, 8'd0, 2'd0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 3'b101, 0);
    checkOutput("pre_reset_run", 0, 0, 3'b000, 8'd3, 2'd0);
    applyStimulus(1, 1, 3'b101, 0);
    checkOutput("reset_run", 0, 0, 3'b000, 8'd0, 2'd0);
    applyStimulus(0, 0, 3'b000, 0);
    checkOutput("post_reset", 0, 0, 3'b000, 8'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
